// File: rtl/fifo_mr_bcast.sv
// fifo_mr_bcast: single-writer broadcast FIFO, each active reader drains every accepted word once at its own pace
// Ports: clk; rst_n async active-low reset; Reset sync active-high clear; active per-reader enable mask;
//        push/data_in write side; pop per-reader read request; data_out/valid/empty/count per reader;
//        full/almost_full back-pressure over active readers; overflow/underflow sticky error flags
module fifo_mr_bcast #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RD_NUM     = 4,
    parameter int AF_MARGIN  = 2,
    parameter int FWFT       = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             Reset,
    input  logic [RD_NUM-1:0]                active,
    input  logic                             push,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic [RD_NUM-1:0]                pop,
    output logic [DATA_WIDTH*RD_NUM-1:0]     data_out,
    output logic [RD_NUM-1:0]                valid,
    output logic [RD_NUM-1:0]                empty,
    output logic                             full,
    output logic                             almost_full,
    output logic [(ADDR_WIDTH+1)*RD_NUM-1:0] count,
    output logic                             overflow,
    output logic [RD_NUM-1:0]                underflow
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(RAM_DEPTH - AF_MARGIN);
    logic [DATA_WIDTH-1:0]               mem [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0]               wr_ptr, wr_next;
    logic [RD_NUM-1:0][ADDR_WIDTH-1:0]   rd_ptr;
    logic [RD_NUM-1:0][ADDR_WIDTH:0]     cnt, cnt_v;
    logic [RD_NUM-1:0][DATA_WIDTH-1:0]   dreg, fw;
    logic [RD_NUM-1:0]                   vreg, pop_ok;
    logic                                push_ok;
    // an inactive reader reads as zero occupancy so it never throttles the writer
    always_comb begin
        full        = 1'b0;
        almost_full = 1'b0;
        for (int i = 0; i < RD_NUM; i++) begin
            cnt_v[i]    = active[i] ? cnt[i] : '0;
            empty[i]    = cnt_v[i] == '0;
            pop_ok[i]   = pop[i] & active[i] & ~empty[i];
            full        = full | (cnt_v[i] == FULL_CNT);
            almost_full = almost_full | (cnt_v[i] >= AF_CNT);
            fw[i]       = empty[i] ? '0 : mem[rd_ptr[i]];
        end
        push_ok = push & ~full;
        wr_next = wr_ptr + ADDR_WIDTH'(push_ok);
    end
    assign count    = cnt_v;
    assign data_out = FWFT != 0 ? fw : dreg;
    assign valid    = FWFT != 0 ? ~empty : vreg;
    always_ff @(posedge clk)
        if (push_ok && !Reset) mem[wr_ptr] <= data_in;
    // inactive readers track the write pointer so they rejoin seeing only new words
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            dreg      <= '0;
            vreg      <= '0;
            overflow  <= 1'b0;
            underflow <= '0;
        end else if (Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            dreg      <= '0;
            vreg      <= '0;
            overflow  <= 1'b0;
            underflow <= '0;
        end else begin
            wr_ptr    <= wr_next;
            vreg      <= pop_ok;
            overflow  <= overflow | (push & full);
            underflow <= underflow | (pop & active & empty);
            for (int i = 0; i < RD_NUM; i++) begin
                rd_ptr[i] <= active[i] ? rd_ptr[i] + ADDR_WIDTH'(pop_ok[i]) : wr_next;
                cnt[i]    <= active[i] ? cnt[i] + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok[i]) : '0;
                if (pop_ok[i]) dreg[i] <= mem[rd_ptr[i]];
            end
        end
endmodule
